// File: rtl/rv32_data_mem_pkg.sv
// Shared pipeline-register types and memory access-type encodings for the
// MEM -> WB boundary of the RV32IC pipeline.
package PipelineReg;

    // State handed from the MEM stage into this block.
    typedef struct packed {
        logic        valid;
        logic [4:0]  rd;
        logic        reg_we;
        logic        is_load;
        logic [31:0] result;
    } MEM_STATE;

    // State handed on to the writeback stage.
    typedef struct packed {
        logic        valid;
        logic [4:0]  rd;
        logic        reg_we;
        logic [31:0] wdata;
    } WBACK_STATE;

    // Access size held in mem_type[1:0]; 2'b11 behaves like a word access.
    localparam logic [1:0] MT_BYTE = 2'b00;
    localparam logic [1:0] MT_HALF = 2'b01;
    localparam logic [1:0] MT_WORD = 2'b10;

    // Bit of mem_type that selects zero-extension (LBU/LHU).
    localparam int MT_UNSIGNED = 2;

endpackage

// File: rtl/rv32_data_mem_lane_align.sv
// Combinational byte-lane steering for the data memory.
// Store side: produces per-lane write enables and replicates the store data
// so every enabled lane already carries the right bits.
// Load side: picks the addressed lane(s) out of the read word and applies
// sign or zero extension.
module dmem_lane_align
    import PipelineReg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DATA_BYTES = DATA_WIDTH / 8
) (
    input  logic [1:0]            addrLo_i,
    input  logic [DATA_BYTES-1:0] memType_i,
    input  logic [DATA_WIDTH-1:0] stData_i,
    input  logic [DATA_WIDTH-1:0] rdWord_i,
    output logic [DATA_BYTES-1:0] byteEn_o,
    output logic [DATA_WIDTH-1:0] stWord_o,
    output logic [DATA_WIDTH-1:0] ldData_o
);

    logic [1:0]  accSize;
    logic        isUnsigned;
    logic [7:0]  laneByte;
    logic [15:0] laneHalf;
    logic        unusedType;

    assign accSize    = memType_i[1:0];
    assign isUnsigned = memType_i[MT_UNSIGNED];
    assign unusedType = ^memType_i[DATA_BYTES-1:3];

    // Pick the addressed byte and halfword; halfwords ignore addr[0] so they stay aligned.
    always_comb begin
        laneByte = rdWord_i[{addrLo_i, 3'b000} +: 8];
        laneHalf = rdWord_i[{addrLo_i[1], 4'b0000} +: 16];
    end

    // Decode the access size into lane enables, store data and extended load data.
    always_comb begin
        byteEn_o = '1;
        stWord_o = stData_i;
        ldData_o = rdWord_i;
        case (accSize)
            MT_BYTE: begin
                byteEn_o = DATA_BYTES'(1) << addrLo_i;
                stWord_o = {DATA_BYTES{stData_i[7:0]}};
                if (isUnsigned) begin
                    ldData_o = {{(DATA_WIDTH-8){1'b0}}, laneByte};
                end else begin
                    ldData_o = {{(DATA_WIDTH-8){laneByte[7]}}, laneByte};
                end
            end
            MT_HALF: begin
                byteEn_o = DATA_BYTES'(3) << {addrLo_i[1], 1'b0};
                stWord_o = {(DATA_BYTES/2){stData_i[15:0]}};
                if (isUnsigned) begin
                    ldData_o = {{(DATA_WIDTH-16){1'b0}}, laneHalf};
                end else begin
                    ldData_o = {{(DATA_WIDTH-16){laneHalf[15]}}, laneHalf};
                end
            end
            default: begin
                byteEn_o = '1;
                stWord_o = stData_i;
                ldData_o = rdWord_i;
            end
        endcase
    end

endmodule

// File: rtl/rv32_data_mem.sv
// Data memory stage (MEM -> WB) of the RV32IC pipeline.
// Holds a word-organised, byte-addressable RAM with byte/half/word stores and
// extended loads, and registers the MEM pipeline state into the WB state with
// load data merged into the writeback value. Reads happen every cycle and see
// the pre-write contents when the same word is written on the same edge.
module rv32_data_mem
    import PipelineReg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int DATA_BYTES  = DATA_WIDTH / 8,
    parameter int DEPTH_WORDS = 1024
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic                  i_we,
    input  logic [DATA_BYTES-1:0] i_mem_type,
    output logic [DATA_WIDTH-1:0] o_rdata,
    input  MEM_STATE              i_mem_state,
    output WBACK_STATE            o_wback_state
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH_WORDS];

    logic [IDX_W-1:0]      wordIdx;
    logic [DATA_WIDTH-1:0] rdWord;
    logic [DATA_BYTES-1:0] byteEn;
    logic [DATA_WIDTH-1:0] stWord;
    logic [DATA_WIDTH-1:0] ldData;
    logic                  unusedAddr;

    logic [DATA_WIDTH-1:0] rdata_d;
    logic [DATA_WIDTH-1:0] rdata_q;
    WBACK_STATE            wback_d;
    WBACK_STATE            wback_q;

    // Upper address bits fall off so the RAM aliases every 4 KiB.
    assign wordIdx    = i_addr[IDX_W+1:2];
    assign unusedAddr = ^i_addr[ADDR_WIDTH-1:IDX_W+2];
    assign rdWord     = mem_q[wordIdx];

    dmem_lane_align #(
        .DATA_WIDTH (DATA_WIDTH),
        .DATA_BYTES (DATA_BYTES)
    ) u_lane_align (
        .addrLo_i  (i_addr[1:0]),
        .memType_i (i_mem_type),
        .stData_i  (i_wdata),
        .rdWord_i  (rdWord),
        .byteEn_o  (byteEn),
        .stWord_o  (stWord),
        .ldData_o  (ldData)
    );

    // Byte-masked RAM write; contents survive reset and reset blocks stores.
    always_ff @(posedge i_clk) begin
        if (i_reset && i_we) begin
            for (int b = 0; b < DATA_BYTES; b++) begin
                if (byteEn[b]) begin
                    mem_q[wordIdx][b*8 +: 8] <= stWord[b*8 +: 8];
                end
            end
        end
    end

    // Next WB state: forward the MEM state, muting reg_we on bubbles and merging load data.
    always_comb begin
        rdata_d        = ldData;
        wback_d        = '0;
        wback_d.valid  = i_mem_state.valid;
        wback_d.rd     = i_mem_state.rd;
        wback_d.reg_we = i_mem_state.reg_we & i_mem_state.valid;
        wback_d.wdata  = i_mem_state.is_load ? ldData : i_mem_state.result;
    end

    // Output registers, cleared by the synchronous active-low reset.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            rdata_q <= '0;
            wback_q <= '0;
        end else begin
            rdata_q <= rdata_d;
            wback_q <= wback_d;
        end
    end

    assign o_rdata       = rdata_q;
    assign o_wback_state = wback_q;

endmodule

// File: tb/tb_rv32_data_mem.sv
// Scoreboard bench for rv32_data_mem: stimulus pushes expectations computed
// from a byte-array reference model; a monitor pops and compares each cycle.
module tb_rv32_data_mem;
    import PipelineReg::*;

    typedef struct {
        bit          chk;
        logic [31:0] rdata;
        WBACK_STATE  wb;
    } exp_t;

    logic        clk;
    logic        resetN;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic [3:0]  memType;
    logic [31:0] rdata;
    MEM_STATE    memState;
    WBACK_STATE  wbState;

    logic [7:0]  modelMem [4096];
    exp_t        expQ [$];
    int          checks = 0;
    int          fails  = 0;
    int          popIdx = 0;

    rv32_data_mem dut (
        .i_clk         (clk),
        .i_reset       (resetN),
        .i_addr        (addr),
        .i_wdata       (wdata),
        .i_we          (we),
        .i_mem_type    (memType),
        .o_rdata       (rdata),
        .i_mem_state   (memState),
        .o_wback_state (wbState)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic MEM_STATE mkMs(input bit v, input int rd, input bit rw,
                                      input bit ld, input logic [31:0] res);
        MEM_STATE m;
        m.valid   = v;
        m.rd      = rd[4:0];
        m.reg_we  = rw;
        m.is_load = ld;
        m.result  = res;
        return m;
    endfunction

    // Reference load: bytes are little-endian in a 4 KiB array.
    function automatic logic [31:0] modelLoad(input logic [31:0] a, input logic [3:0] mt);
        int          p;
        logic [31:0] v;
        p = int'(a % 32'd4096);
        if (mt[1:0] == 2'b00) begin
            v = {24'h0, modelMem[p]};
            if (!mt[2] && v[7]) v = v | 32'hFFFF_FF00;
        end else if (mt[1:0] == 2'b01) begin
            p = p - (p % 2);
            v = {16'h0, modelMem[p+1], modelMem[p]};
            if (!mt[2] && v[15]) v = v | 32'hFFFF_0000;
        end else begin
            p = p - (p % 4);
            v = {modelMem[p+3], modelMem[p+2], modelMem[p+1], modelMem[p]};
        end
        return v;
    endfunction

    function automatic void modelStore(input logic [31:0] a, input logic [31:0] d,
                                       input logic [3:0] mt);
        int p;
        p = int'(a % 32'd4096);
        if (mt[1:0] == 2'b00) begin
            modelMem[p] = d[7:0];
        end else if (mt[1:0] == 2'b01) begin
            p = p - (p % 2);
            modelMem[p]   = d[7:0];
            modelMem[p+1] = d[15:8];
        end else begin
            p = p - (p % 4);
            for (int k = 0; k < 4; k++) modelMem[p+k] = d[8*k +: 8];
        end
    endfunction

    task automatic applyStimulus(input bit rst, input bit w, input logic [31:0] a,
                                 input logic [31:0] d, input logic [3:0] mt,
                                 input MEM_STATE ms, input bit chk);
        exp_t        e;
        logic [31:0] ld;
        @(negedge clk);
        resetN   = rst;
        we       = w;
        addr     = a;
        wdata    = d;
        memType  = mt;
        memState = ms;
        ld       = modelLoad(a, mt);
        e.chk    = chk;
        if (!rst) begin
            e.rdata = '0;
            e.wb    = '0;
        end else begin
            e.rdata     = ld;
            e.wb.valid  = ms.valid;
            e.wb.rd     = ms.rd;
            e.wb.reg_we = ms.reg_we & ms.valid;
            e.wb.wdata  = ms.is_load ? ld : ms.result;
            if (w) modelStore(a, d, mt);
        end
        expQ.push_back(e);
    endtask

    task automatic checkOutput(input exp_t e);
        checks++;
        if (rdata !== e.rdata) begin
            fails++;
            $display("[TB] FAIL rdata #%0d: got %h expected %h", popIdx, rdata, e.rdata);
        end
        checks++;
        if (wbState !== e.wb) begin
            fails++;
            $display("[TB] FAIL wback #%0d: got %h expected %h", popIdx, wbState, e.wb);
        end
    endtask

    // Monitor: every edge retires the oldest expectation.
    always @(posedge clk) begin
        exp_t e;
        #2;
        if (expQ.size() > 0) begin
            e = expQ.pop_front();
            if (e.chk) checkOutput(e);
            popIdx++;
        end
    end

    initial begin
        MEM_STATE idle;
        MEM_STATE ldMs;
        idle     = mkMs(0, 0, 0, 0, 32'h0);
        ldMs     = mkMs(1, 7, 1, 1, 32'hCAFE_0000);
        resetN   = 1'b0;
        we       = 1'b0;
        addr     = '0;
        wdata    = '0;
        memType  = 4'b0010;
        memState = idle;

        // Reset state
        applyStimulus(0, 0, 32'h0, 32'h0, 4'b0010, mkMs(1, 3, 1, 0, 32'h55), 1);
        applyStimulus(0, 0, 32'h0, 32'h0, 4'b0010, idle, 1);

        // Preload every word so loads never see uninitialised RAM
        for (int i = 0; i < 1024; i++) begin
            applyStimulus(1, 1, i * 4, $urandom, 4'b0010, idle, 0);
        end

        // Word store then load
        applyStimulus(1, 1, 32'h10, 32'hDEAD_BEEF, 4'b0010, idle, 1);
        applyStimulus(1, 0, 32'h10, 32'h0, 4'b0010, ldMs, 1);

        // Byte store over zero word, signed/unsigned/word loads
        applyStimulus(1, 1, 32'h20, 32'h0, 4'b0010, idle, 1);
        applyStimulus(1, 1, 32'h21, 32'h80, 4'b0000, idle, 1);
        applyStimulus(1, 0, 32'h21, 32'h0, 4'b0000, ldMs, 1);
        applyStimulus(1, 0, 32'h21, 32'h0, 4'b0100, ldMs, 1);
        applyStimulus(1, 0, 32'h20, 32'h0, 4'b0010, ldMs, 1);

        // Half store, signed/unsigned/other-half loads
        applyStimulus(1, 1, 32'h32, 32'h1234_BEEF, 4'b0001, idle, 1);
        applyStimulus(1, 0, 32'h32, 32'h0, 4'b0001, ldMs, 1);
        applyStimulus(1, 0, 32'h33, 32'h0, 4'b0101, ldMs, 1);
        applyStimulus(1, 0, 32'h30, 32'h0, 4'b0001, ldMs, 1);

        // Address wrap and read-first on same-word read/write
        applyStimulus(1, 1, 32'h1004, 32'hA5A5_0001, 4'b1011, idle, 1);
        applyStimulus(1, 0, 32'h0004, 32'h0, 4'b0010, ldMs, 1);
        applyStimulus(1, 1, 32'h40, 32'h1111_2222, 4'b0010, ldMs, 1);
        applyStimulus(1, 0, 32'h40, 32'h0, 4'b0010, ldMs, 1);

        // Pipeline register pass-through, bubble masking of reg_we
        applyStimulus(1, 0, 32'h10, 32'h0, 4'b0010, mkMs(1, 5, 1, 0, 32'h1234), 1);
        applyStimulus(1, 0, 32'h10, 32'h0, 4'b0010, mkMs(1, 5, 1, 1, 32'h1234), 1);
        applyStimulus(1, 0, 32'h10, 32'h0, 4'b0010, mkMs(0, 9, 1, 0, 32'h77), 1);

        // Reset blocks stores and discards an in-flight load
        applyStimulus(0, 1, 32'h40, 32'h5555_5555, 4'b0010, ldMs, 1);
        applyStimulus(1, 0, 32'h40, 32'h0, 4'b0010, ldMs, 1);
        applyStimulus(0, 0, 32'h21, 32'h0, 4'b0000, ldMs, 1);

        // Randomized traffic over the full address space
        for (int i = 0; i < 400; i++) begin
            applyStimulus($urandom_range(0, 19) != 0, $urandom_range(0, 1) == 1,
                          $urandom, $urandom, 4'($urandom),
                          mkMs($urandom_range(0, 1) == 1, $urandom_range(0, 31),
                               $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                               $urandom), 1);
        end

        @(negedge clk);
        we       = 1'b0;
        memState = idle;
        @(negedge clk);
        @(negedge clk);

        checks++;
        if (expQ.size() != 0) begin
            fails++;
            $display("[TB] FAIL drain: got %0d pending expected 0", expQ.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
